// File: rtl/fetch_stepper.sv
// fetch_stepper: instruction-cycle sequencer for the 8-bit processor.
// Walks IDLE -> F1 -> F2 -> F3 -> E1..En and emits Moore register strobes for the
// IAR/MAR/IR/ACC datapath, then hands execute steps to the decoder.
// Optional feature macro: FETCH_STEPPER_RETIRE_CNT_EN adds an 8-bit retire counter.
// EXEC_STEPS must be in 1..3.

module fetch_stepper #(
    parameter int unsigned EXEC_STEPS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       halt_req,
    input  logic       exec_last,
    output logic       OIAR,
    output logic       IIAR,
    output logic       IMAR,
    output logic       BUS1,
    output logic       IACC,
    output logic       OACC,
    output logic       ORAM,
    output logic       IIR,
    output logic [2:0] exec_step,
    output logic       busy,
    output logic       halted
`ifdef FETCH_STEPPER_RETIRE_CNT_EN
    ,
    output logic [7:0] retire_cnt
`endif
);

    // One-hot state encoding; outputs decode straight from the register.
    typedef enum logic [7:0] {
        StIdle = 8'b0000_0001,
        StF1   = 8'b0000_0010,
        StF2   = 8'b0000_0100,
        StF3   = 8'b0000_1000,
        StE1   = 8'b0001_0000,
        StE2   = 8'b0010_0000,
        StE3   = 8'b0100_0000,
        StHalt = 8'b1000_0000
    } state_e;

    state_e state_q, state_d;
    logic   halt_q, halt_d;
    logic   halt_now;
    logic   retire;

    // Request seen this cycle counts as pending immediately.
    assign halt_now = halt_q | halt_req;
    assign halt_d   = halt_now;

    // State and sticky halt flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state logic; retire picks HALT over F1 over IDLE.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (halt_now) begin
                    state_d = StHalt;
                end else if (run) begin
                    state_d = StF1;
                end
            end
            StF1: state_d = StF2;
            StF2: state_d = StF3;
            StF3: state_d = StE1;
            StE1: begin
                if (exec_last || (EXEC_STEPS == 1)) begin
                    retire = 1'b1;
                end else begin
                    state_d = StE2;
                end
            end
            StE2: begin
                if (exec_last || (EXEC_STEPS == 2)) begin
                    retire = 1'b1;
                end else begin
                    state_d = StE3;
                end
            end
            StE3:   retire  = 1'b1;
            StHalt: state_d = StHalt;
            // Illegal encodings recover to IDLE.
            default: state_d = StIdle;
        endcase
        if (retire) begin
            if (halt_now) begin
                state_d = StHalt;
            end else if (run) begin
                state_d = StF1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Moore strobe decode; each state enables at most one bus driver.
    always_comb begin
        OIAR      = 1'b0;
        IIAR      = 1'b0;
        IMAR      = 1'b0;
        BUS1      = 1'b0;
        IACC      = 1'b0;
        OACC      = 1'b0;
        ORAM      = 1'b0;
        IIR       = 1'b0;
        exec_step = 3'b000;
        busy      = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            StF1: begin
                OIAR = 1'b1;
                IMAR = 1'b1;
                BUS1 = 1'b1;
                IACC = 1'b1;
                busy = 1'b1;
            end
            StF2: begin
                ORAM = 1'b1;
                IIR  = 1'b1;
                busy = 1'b1;
            end
            StF3: begin
                OACC = 1'b1;
                IIAR = 1'b1;
                busy = 1'b1;
            end
            StE1: begin
                exec_step = 3'b001;
                busy      = 1'b1;
            end
            StE2: begin
                exec_step = 3'b010;
                busy      = 1'b1;
            end
            StE3: begin
                exec_step = 3'b100;
                busy      = 1'b1;
            end
            // HALT reports halted but not busy.
            StHalt: halted = 1'b1;
            default: ;
        endcase
    end

`ifdef FETCH_STEPPER_RETIRE_CNT_EN
    // Retired-instruction counter; no retire occurs in HALT so it freezes there.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= 8'd0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stepper.sv
// Directed bench for fetch_stepper with a small IAR/MAR/ACC/IR/RAM datapath model.
// Optional checks follow FETCH_STEPPER_RETIRE_CNT_EN.

module tb_fetch_stepper;

    logic       clk;
    logic       reset;
    logic       run;
    logic       halt_req;
    logic       exec_last;
    logic       OIAR, IIAR, IMAR, BUS1, IACC, OACC, ORAM, IIR;
    logic [2:0] exec_step;
    logic       busy;
    logic       halted;
`ifdef FETCH_STEPPER_RETIRE_CNT_EN
    logic [7:0] retire_cnt;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    fetch_stepper #(.EXEC_STEPS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .halt_req  (halt_req),
        .exec_last (exec_last),
        .OIAR      (OIAR),
        .IIAR      (IIAR),
        .IMAR      (IMAR),
        .BUS1      (BUS1),
        .IACC      (IACC),
        .OACC      (OACC),
        .ORAM      (ORAM),
        .IIR       (IIR),
        .exec_step (exec_step),
        .busy      (busy),
        .halted    (halted)
`ifdef FETCH_STEPPER_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {OIAR,IIAR,IMAR,BUS1,IACC,OACC,ORAM,IIR,exec_step[2:0],busy,halted}
    logic [12:0] outs;
    assign outs = {OIAR, IIAR, IMAR, BUS1, IACC, OACC, ORAM, IIR, exec_step, busy, halted};

    localparam logic [12:0] S_IDLE = 13'b0_0_0_0_0_0_0_0_000_0_0;
    localparam logic [12:0] S_F1   = 13'b1_0_1_1_1_0_0_0_000_1_0;
    localparam logic [12:0] S_F2   = 13'b0_0_0_0_0_0_1_1_000_1_0;
    localparam logic [12:0] S_F3   = 13'b0_1_0_0_0_1_0_0_000_1_0;
    localparam logic [12:0] S_E1   = 13'b0_0_0_0_0_0_0_0_001_1_0;
    localparam logic [12:0] S_E2   = 13'b0_0_0_0_0_0_0_0_010_1_0;
    localparam logic [12:0] S_E3   = 13'b0_0_0_0_0_0_0_0_100_1_0;
    localparam logic [12:0] S_HALT = 13'b0_0_0_0_0_0_0_0_000_0_1;

    // Datapath model: RAM[a] = a ^ 0xA5, ALU adds BUS1 to the bus value.
    logic [7:0] iar, acc, mar, ir, bus;
    always_comb begin
        bus = 8'h00;
        if (OIAR)      bus = iar;
        else if (OACC) bus = acc;
        else if (ORAM) bus = mar ^ 8'hA5;
    end

    always @(posedge clk) begin
        if (reset) begin
            iar <= 8'h05;
            acc <= 8'h00;
            mar <= 8'h00;
            ir  <= 8'h00;
        end else begin
            if (IMAR) mar <= bus;
            if (IACC) acc <= bus + {7'd0, BUS1};
            if (IIR)  ir  <= bus;
            if (IIAR) iar <= bus;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_chk(input string tag, input logic [12:0] exp);
        tick();
        chk(tag, {3'b000, outs}, {3'b000, exp});
    endtask

    initial begin
        int viol;
        reset = 1'b1; run = 1'b0; halt_req = 1'b0; exec_last = 1'b0;
        tick();
        step_chk("reset_idle", S_IDLE);

        // Full 3+3 instruction, then back-to-back F1.
        reset = 1'b0; run = 1'b1;
        step_chk("seq_f1", S_F1);
        step_chk("seq_f2", S_F2);
        step_chk("seq_f3", S_F3);
        step_chk("seq_e1", S_E1);
        chk("iar_inc", {8'h00, iar}, 16'h0006);
        chk("ir_fetch", {8'h00, ir}, 16'h00A0);
        step_chk("seq_e2", S_E2);
        step_chk("seq_e3", S_E3);
        step_chk("b2b_f1", S_F1);

        // exec_last in E1: four-cycle instruction.
        step_chk("i2_f2", S_F2);
        step_chk("i2_f3", S_F3);
        step_chk("i2_e1", S_E1);
        exec_last = 1'b1;
        step_chk("last_e1_f1", S_F1);
        exec_last = 1'b0;
        chk("iar_inc2", {8'h00, iar}, 16'h0007);

        // Halt pulse during F2 completes the instruction first.
        step_chk("h_f2", S_F2);
        halt_req = 1'b1;
        step_chk("h_f3", S_F3);
        halt_req = 1'b0;
        step_chk("h_e1", S_E1);
        step_chk("h_e2", S_E2);
        step_chk("h_e3", S_E3);
        step_chk("halt_after_retire", S_HALT);
        for (int i = 0; i < 20; i++) step_chk("halt_hold", S_HALT);

        // Reset out of HALT, then abort mid-F3.
        reset = 1'b1;
        step_chk("reset_from_halt", S_IDLE);
        reset = 1'b0;
        step_chk("r_f1", S_F1);
        step_chk("r_f2", S_F2);
        step_chk("r_f3", S_F3);
        reset = 1'b1;
        step_chk("reset_abort", S_IDLE);
        reset = 1'b0; run = 1'b0;
        step_chk("idle_hold", S_IDLE);
        step_chk("idle_hold2", S_IDLE);
        run = 1'b1;
        step_chk("clean_f1", S_F1);

        // run dropped mid-instruction; exec_last ignored during fetch.
        run = 1'b0; exec_last = 1'b1;
        step_chk("f2_ignores_last", S_F2);
        step_chk("f3_ignores_last", S_F3);
        step_chk("e1_runs", S_E1);
        step_chk("retire_idle", S_IDLE);
        exec_last = 1'b0;

        // halt_req with exec_last in the same cycle.
        run = 1'b1;
        step_chk("hl_f1", S_F1);
        step_chk("hl_f2", S_F2);
        step_chk("hl_f3", S_F3);
        step_chk("hl_e1", S_E1);
        exec_last = 1'b1; halt_req = 1'b1;
        step_chk("halt_and_last", S_HALT);
        exec_last = 1'b0; halt_req = 1'b0;

        // Halt request in IDLE beats run.
        reset = 1'b1;
        step_chk("reset_again", S_IDLE);
        reset = 1'b0; halt_req = 1'b1; run = 1'b1;
        step_chk("idle_halt", S_HALT);
        halt_req = 1'b0;

        // Random run/exec_last: bus drivers stay mutually exclusive.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        viol = 0;
        for (int i = 0; i < 10000; i++) begin
            run       = 1'($urandom_range(0, 1));
            exec_last = 1'($urandom_range(0, 1));
            tick();
            if ((int'(OIAR) + int'(OACC) + int'(ORAM)) > 1) viol++;
        end
        chk("bus_onehot", viol[15:0], 16'd0);

`ifdef FETCH_STEPPER_RETIRE_CNT_EN
        reset = 1'b1; run = 1'b0; exec_last = 1'b0;
        tick();
        chk("cnt_reset", {8'h00, retire_cnt}, 16'd0);
        reset = 1'b0; run = 1'b1; exec_last = 1'b1;
        tick();
        repeat (4 * 255) tick();
        chk("cnt_255", {8'h00, retire_cnt}, 16'd255);
        repeat (4) tick();
        chk("cnt_wrap", {8'h00, retire_cnt}, 16'd0);
        repeat (8) tick();
        chk("cnt_2", {8'h00, retire_cnt}, 16'd2);
        reset = 1'b1;
        tick();
        chk("cnt_reset2", {8'h00, retire_cnt}, 16'd0);
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
